// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rx line, oversampled bit timing driven by
// baud_tick16, LSB-first 8-bit frames with one stop bit.
// Build option: define RX_PARITY_EN for 8E1 frames. This adds a PARITY state
// and a live parity_err output. Left undefined, frames are 8N1 and
// parity_err is tied low.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       baud_tick16,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] S_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(OVERSAMPLE - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic             rx_meta_p0;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] s_cnt;
    logic [2:0]       nbit;
    logic [7:0]       shreg;
`ifdef RX_PARITY_EN
    logic             par_bad;

    // Even parity: the parity bit plus the data bits must hold an even
    // number of ones, so any nonzero XOR is a mismatch.
    function automatic logic parity_mismatch(input logic par_bit,
                                             input logic [7:0] bits);
        return par_bit ^ (^bits);
    endfunction
`endif

    // Two-flop synchroniser. It resets to the idle (high) level so that
    // leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= rx;
            rx_s       <= rx_meta_p0;
        end
    end

    // Frame FSM: bit timing, data shifting and the registered result pulses.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            s_cnt     <= '0;
            nbit      <= '0;
            shreg     <= '0;
            data_out  <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // The start edge is taken immediately, not on a tick,
                    // so back-to-back frames lose no time.
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_tick16) begin
                        if (s_cnt == S_MID) begin
                            // A line that is high again at mid-start is a
                            // glitch. Drop it silently.
                            state <= rx_s ? IDLE : DATA;
                            s_cnt <= '0;
                            nbit  <= '0;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick16) begin
                        if (s_cnt == S_LAST) begin
                            shreg <= {rx_s, shreg[7:1]};
                            nbit  <= nbit + 1'b1;
                            s_cnt <= '0;
                            if (nbit == 3'd7) begin
`ifdef RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (baud_tick16) begin
                        if (s_cnt == S_LAST) begin
                            par_bad <= parity_mismatch(rx_s, shreg);
                            state   <= STOP;
                            s_cnt   <= '0;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (baud_tick16) begin
                        if (s_cnt == S_LAST) begin
                            state <= IDLE;
                            s_cnt <= '0;
                            // Exactly one outcome per frame. data_out only
                            // moves on a clean frame.
                            if (!rx_s) begin
                                frame_err <= 1'b1;
`ifdef RX_PARITY_EN
                            end else if (par_bad) begin
                                parity_err <= 1'b1;
`endif
                            end else begin
                                data_out <= shreg;
                                rx_valid <= 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    s_cnt <= '0;
                end
            endcase
        end
    end

`ifndef RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Busy covers every state other than IDLE.
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVERSAMPLE=16: one tick every 4 clk, so one
// bit lasts 64 clk. Compile with RX_PARITY_EN for the 8E1 variant.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       baud_tick16 = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    int n_valid = 0;
    int n_ferr  = 0;
    int n_perr  = 0;
    int n_multi = 0;
    logic [7:0] vlog [0:31];

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .baud_tick16(baud_tick16),
        .rx         (rx),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Tick generator: one clk-wide pulse every 4 clk.
    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            k = (k + 1) % 4;
            baud_tick16 = (k == 0);
        end
    end

    // Pulse monitor: counts high cycles of each result output and logs the
    // received bytes.
    always @(negedge clk) begin
        if (rx_valid) begin
            vlog[n_valid % 32] <= data_out;
            n_valid <= n_valid + 1;
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (parity_err) n_perr <= n_perr + 1;
        if ((32'(rx_valid) + 32'(frame_err) + 32'(parity_err)) > 1) n_multi <= n_multi + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame, bit by bit, 64 clk per bit. The line returns high
    // part-way through the stop bit, after the mid-stop sample, so a low
    // stop bit cannot trigger a follow-on frame. rst_at >= 0 pulses
    // areset_n at that clk offset into the frame and checks the reset
    // values there.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic par_bit, input int rst_at,
                              output int busy_low);
        logic [10:0] bits;
        int nb;
        int g;
        busy_low = 0;
`ifdef RX_PARITY_EN
        bits = {stop_bit, par_bit, b, 1'b0};
        nb = 11;
`else
        bits = {par_bit, stop_bit, b, 1'b0};
        nb = 10;
`endif
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < 64; c++) begin
                @(negedge clk);
                if (c == 0) rx = bits[i];
                if (i == nb - 1 && c == 40) rx = 1'b1;
                g = i * 64 + c;
                if (g == rst_at) begin
                    areset_n = 1'b0;
                    #1;
                    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out: got %h want 00", data_out); end
                    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid); end
                    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
                    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_parity_err: got %b want 0", parity_err); end
                    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
                end
                if (rst_at >= 0 && g == rst_at + 8) areset_n = 1'b1;
                if (g >= 4 && g < (nb - 1) * 64 && busy !== 1'b1) busy_low++;
            end
        end
    endtask

    task automatic test_reset();
        idle(3);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        areset_n = 1'b1;
        idle(10);
    endtask

    task automatic test_good_frame();
        int v0, f0, p0, bl;
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        send_frame(8'hA5, 1'b1, ^8'hA5, -1, bl);
        idle(20);
        checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL good_valid_count: got %0d want 1", n_valid - v0); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL good_data_out: got %h want a5", data_out); end
        checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL good_frame_err: got %0d want 0", n_ferr - f0); end
        checks++; if (n_perr - p0 != 0) begin errors++; $display("FAIL good_parity_err: got %0d want 0", n_perr - p0); end
        checks++; if (bl != 0) begin errors++; $display("FAIL good_busy_held: got %0d low cycles want 0", bl); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        @(negedge clk); rx = 1'b0;
        idle(10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
        idle(6);
        rx = 1'b1;
        idle(32);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_back_idle: got %b want 0", busy); end
        idle(100);
        checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", n_valid - v0); end
        checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL glitch_frame_err: got %0d want 0", n_ferr - f0); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL glitch_data_out: got %h want a5", data_out); end
    endtask

    task automatic test_frame_err();
        int v0, f0, bl;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, ^8'h3C, -1, bl);
        idle(100);
        checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles want 1", n_ferr - f0); end
        checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL ferr_valid: got %0d want 0", n_valid - v0); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL ferr_data_out: got %h want a5", data_out); end
    endtask

    task automatic test_reset_mid();
        int v0, f0, bl;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'hFF, 1'b1, ^8'hFF, 4 * 64 + 32, bl);
        idle(50);
        checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d want 0", n_valid - v0); end
        send_frame(8'h5A, 1'b1, ^8'h5A, -1, bl);
        idle(20);
        checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL rstmid_valid_count: got %0d want 1", n_valid - v0); end
        checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL rstmid_data_out: got %h want 5a", data_out); end
        checks++; if (n_ferr - f0 != 0) begin errors++; $display("FAIL rstmid_frame_err: got %0d want 0", n_ferr - f0); end
    endtask

    task automatic test_back_to_back();
        int v0, bl;
        v0 = n_valid;
        send_frame(8'h00, 1'b1, ^8'h00, -1, bl);
        send_frame(8'hFF, 1'b1, ^8'hFF, -1, bl);
        idle(20);
        checks++; if (n_valid - v0 != 2) begin errors++; $display("FAIL b2b_valid_count: got %0d want 2", n_valid - v0); end
        checks++; if (vlog[v0 % 32] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", vlog[v0 % 32]); end
        checks++; if (vlog[(v0 + 1) % 32] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", vlog[(v0 + 1) % 32]); end
    endtask

    task automatic test_parity();
`ifdef RX_PARITY_EN
        int v0, p0, bl;
        v0 = n_valid; p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b0, -1, bl);
        idle(20);
        checks++; if (n_perr - p0 != 1) begin errors++; $display("FAIL parity_err_pulse: got %0d cycles want 1", n_perr - p0); end
        checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL parity_valid: got %0d want 0", n_valid - v0); end
        checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL parity_data_out: got %h want ff", data_out); end
`else
        checks++; if (n_perr != 0) begin errors++; $display("FAIL parity_tied_low: got %0d high cycles want 0", n_perr); end
`endif
    endtask

    task automatic test_exclusive();
        checks++; if (n_multi != 0) begin errors++; $display("FAIL exclusive_pulses: got %0d overlap cycles want 0", n_multi); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_back_to_back();
        test_parity();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, 16, number of baud_tick16 pulses per bit period; even, 8..32.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: areset_n  input  1  reset; asynchronous and active-low.
REQ-004 Port: baud_tick16  input  1  single-cycle enable pulse at OVERSAMPLE x baud rate.
REQ-005 Port: rx  input  1  asynchronous serial line; idle high; 8N1 frames (8E1 with RX_PARITY_EN); LSB first.
REQ-006 Port: data_out  output  8  last correctly received byte; held until the next good frame.
REQ-007 Port: rx_valid  output  1  one-clk pulse; data_out updated on the same edge.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: frame_err  output  1  one-clk pulse; stop bit sampled low.
REQ-010 Port: parity_err  output  1  one-clk pulse; parity mismatch; constant 0 without RX_PARITY_EN.

Function
REQ-011 rx SHALL pass through a 2-FF synchronizer; all internal decisions SHALL use the synchronized value rx_s.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY SHALL exist only with RX_PARITY_EN.
REQ-013 Sample counter s_cnt (width clog2(OVERSAMPLE)) SHALL advance only on baud_tick16 and SHALL clear on every state change.
REQ-014 IDLE: rx_s==0 -> START with s_cnt=0 on the same clk, without waiting for a tick.
REQ-015 START: on the tick where s_cnt==OVERSAMPLE/2-1, rx_s==0 -> DATA; rx_s==1 -> IDLE as a glitch, with no output pulse.
REQ-016 DATA: on the tick where s_cnt==OVERSAMPLE-1:
  - shift rx_s into shreg[7], shifting right;
  - increment bit counter nbit (3 bits);
  - after the 8th bit -> PARITY if enabled, else STOP.
REQ-017 PARITY: on the tick where s_cnt==OVERSAMPLE-1, latch par_bad = (rx_s ^ ^shreg) != 0 for even parity, then -> STOP.
REQ-018 STOP: on the tick where s_cnt==OVERSAMPLE-1, -> IDLE, with one result on the same edge:
  - rx_s==0: frame_err=1.
  - rx_s==1 and par_bad: parity_err=1.
  - otherwise: data_out<=shreg and rx_valid=1.
REQ-019 At most one of rx_valid, frame_err and parity_err SHALL be high in any cycle.
REQ-020 data_out SHALL NOT change on a glitch, frame error or parity error.
REQ-021 Ticks arriving while in IDLE SHALL be ignored.
REQ-022 A new start edge SHALL be accepted from the first clk after the return to IDLE, so back-to-back frames are received with zero idle bits between them.
REQ-023 Latency: rx_valid SHALL assert 1 clk after the baud_tick16 that samples mid-stop, relative to synchronized rx.
REQ-024 rx_valid, frame_err and parity_err SHALL be registered outputs.

Reset
REQ-025 While areset_n==0, the following values SHALL apply immediately, independent of clk:
  - state=IDLE; s_cnt=0; nbit=0; shreg=0; par_bad=0;
  - both synchronizer FFs=1;
  - data_out=8'h00; rx_valid=0; frame_err=0; parity_err=0; busy=0.
REQ-026 Reset mid-frame SHALL discard the partial byte; after release, reception SHALL restart at the next falling edge of rx_s.

Configuration
REQ-027 Macro RX_PARITY_EN defined: frames are 8E1; the PARITY state and parity_err are active.
REQ-028 RX_PARITY_EN undefined: frames are 8N1; DATA goes directly to STOP; par_bad is removed and parity_err is tied to 0.

Verification (OVERSAMPLE=16, one tick every 4 clk, bit period 64 clk)
REQ-029 Frame 0xA5 with good stop (plus correct parity if enabled) -> exactly one rx_valid pulse, data_out=0xA5, frame_err=0, busy high for the whole frame.
REQ-030 rx low for 4 ticks then high -> returns to IDLE at the mid-start check; no pulses; data_out unchanged.
REQ-031 After 0xA5, send 0x3C with stop bit=0 -> frame_err single pulse, no rx_valid, data_out stays 0xA5.
REQ-032 Assert areset_n low during bit 3 of 0xFF, release, then send 0x5A -> all outputs are reset values during reset, then one rx_valid with data_out=0x5A.
REQ-033 Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_valid pulses with data_out 0x00 then 0xFF.
REQ-034 With RX_PARITY_EN, send 0x07 with parity bit 0 (correct value is 1) -> parity_err pulse, no rx_valid, data_out unchanged.
